// File: rtl/regfile_wr_arbiter.sv
// Register-file write arbiter: two requester FIFOs (A = ALU, B = load)
// feeding one register-file write port through a round-robin pop, with a
// combinational hazard query over queued and in-flight writes.

// One requester queue: circular buffer plus a hazard match over live entries.
module regfile_wr_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              not_full,
  output logic              not_empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              hit
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]                   count;
  logic [PW-1:0]                 wptr, rptr, off;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_mem;
  logic [DEPTH-1:0][DATA_W-1:0]  data_mem;

  assign not_full  = count < (PW+1)'(DEPTH);
  assign not_empty = count != '0;
  assign head_addr = addr_mem[rptr];
  assign head_data = data_mem[rptr];

  // Pointers and occupancy; power-of-two DEPTH lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Entry storage; contents only matter while counted as live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr] <= push_addr;
      data_mem[wptr] <= push_data;
    end
  end

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rptr;
      if (({1'b0, off} < count) && (addr_mem[i] == q_addr)) hit = 1'b1;
    end
  end
endmodule

module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending
);
  localparam int NUM_REQ = 2;  // index 0 = A, 1 = B

  logic [NUM_REQ-1:0]             valid, push, pop, not_full, not_empty, hit;
  logic [NUM_REQ-1:0][ADDR_W-1:0] in_addr, head_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] in_data, head_data;
  logic                           last_b, grant_b, pop_any;
  logic [ADDR_W-1:0]              sel_addr;
  logic [DATA_W-1:0]              sel_data;

  assign valid   = {b_valid, a_valid};
  assign in_addr = {b_addr, a_addr};
  assign in_data = {b_data, a_data};

  // Ready comes from registered occupancy only and is forced low in reset.
  assign a_ready = reset & not_full[0];
  assign b_ready = reset & not_full[1];
  assign push    = valid & {b_ready, a_ready};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_q
    regfile_wr_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_q (
      .clk       (clk),
      .reset     (reset),
      .push      (push[g]),
      .push_addr (in_addr[g]),
      .push_data (in_data[g]),
      .pop       (pop[g]),
      .q_addr    (q_addr),
      .not_full  (not_full[g]),
      .not_empty (not_empty[g]),
      .head_addr (head_addr[g]),
      .head_data (head_data[g]),
      .hit       (hit[g])
    );
  end

  // Round-robin pick among queues that were non-empty before this edge, so
  // a same-edge push never bypasses the queue.
  always_comb begin
    grant_b  = not_empty[1] & (~not_empty[0] | ~last_b);
    pop_any  = |not_empty;
    pop      = {pop_any & grant_b, pop_any & ~grant_b};
    sel_addr = grant_b ? head_addr[1] : head_addr[0];
    sel_data = grant_b ? head_data[1] : head_data[0];
  end

  // Write port stage; address-0 pops are consumed but never strobe wr_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      last_b  <= 1'b1;
    end else begin
      wr_en <= pop_any && (sel_addr != '0);
      if (pop_any && (sel_addr != '0)) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
      if (pop_any) last_b <= grant_b;
    end
  end

  assign q_pending = reset && (q_addr != '0) &&
                     ((|hit) || (wr_en && (wr_addr == q_addr)));
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: constant vector table, directed corner
// sequences, and random traffic scored against a queue-based model.
module tb_regfile_wr_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready, wr_en, q_pending;
  logic [4:0]  a_addr, b_addr, wr_addr, q_addr;
  logic [31:0] a_data, b_data, wr_data;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .q_addr(q_addr), .q_pending(q_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic [4:0] qa;
    logic ar, br, qp;
    logic we; logic [4:0] wa; logic [31:0] wd;
  } vec_t;

  int passed = 0, total = 0;

  // Reference model: two plain FIFOs, who was served last, and the expected
  // write-port contents.
  ent_t        qa[$], qb[$];
  logic        m_last_b;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        acc_a, acc_b;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    m_last_b = 1'b1; m_we = 1'b0; m_wa = '0; m_wd = '0;
    acc_a = 1'b1; acc_b = 1'b1;
  endtask

  function automatic logic model_pending(logic [4:0] q);
    logic p = 1'b0;
    if (q == 0) return 1'b0;
    foreach (qa[i]) if (qa[i].addr == q) p = 1'b1;
    foreach (qb[i]) if (qb[i].addr == q) p = 1'b1;
    if (m_we && m_wa == q) p = 1'b1;
    return p;
  endfunction

  // One clock with reset high: check combinational outputs, advance the model
  // by the arbitration rules, clock, then check the write port.
  task automatic run_cycle();
    ent_t e;
    logic popped;
    #1;
    chk("a_ready", a_ready, qa.size() < DEPTH);
    chk("b_ready", b_ready, qb.size() < DEPTH);
    chk("q_pending", q_pending, model_pending(q_addr));
    acc_a = a_valid && (qa.size() < DEPTH);
    acc_b = b_valid && (qb.size() < DEPTH);
    popped = 1'b0;
    m_we = 1'b0;
    if (qa.size() > 0 && (qb.size() == 0 || m_last_b)) begin
      e = qa.pop_front(); m_last_b = 1'b0; popped = 1'b1;
    end else if (qb.size() > 0) begin
      e = qb.pop_front(); m_last_b = 1'b1; popped = 1'b1;
    end
    if (popped && e.addr != 0) begin
      m_we = 1'b1; m_wa = e.addr; m_wd = e.data;
    end
    if (acc_a) qa.push_back('{a_addr, a_data});
    if (acc_b) qb.push_back('{b_addr, b_data});
    @(posedge clk);
    @(negedge clk);
    chk("wr_en", wr_en, m_we);
    chk("wr_addr", wr_addr, m_wa);
    chk("wr_data", wr_data, m_wd);
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0;
  endtask

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic [4:0] qa_, logic ar, logic br, logic qp,
                              logic we, logic [4:0] wa, logic [31:0] wd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.qa = qa_; v.ar = ar; v.br = br; v.qp = qp; v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Contention right after reset: A wins first, then strict alternation.
    tbl.push_back(mk(1,1,'hA1, 1,11,'hB1,  2, 1,1,0, 0, 0,0));
    tbl.push_back(mk(1,2,'hA2, 1,12,'hB2,  2, 1,1,0, 1, 1,'hA1));
    tbl.push_back(mk(1,3,'hA3, 1,13,'hB3,  2, 1,0,1, 1,11,'hB1));
    tbl.push_back(mk(0,0,0,    1,13,'hB3,  2, 0,1,1, 1, 2,'hA2));
    tbl.push_back(mk(0,0,0,    0,0,0,      2, 1,0,1, 1,12,'hB2));
    tbl.push_back(mk(0,0,0,    0,0,0,      2, 1,1,0, 1, 3,'hA3));
    tbl.push_back(mk(0,0,0,    0,0,0,      2, 1,1,0, 1,13,'hB3));
    tbl.push_back(mk(0,0,0,    0,0,0,      2, 1,1,0, 0,13,'hB3));
    // Single write to r5, one-cycle strobe, hazard visible until written.
    tbl.push_back(mk(1,5,'h1234, 0,0,0,    5, 1,1,0, 0,13,'hB3));
    tbl.push_back(mk(0,0,0,    0,0,0,      5, 1,1,1, 1, 5,'h1234));
    tbl.push_back(mk(0,0,0,    0,0,0,      5, 1,1,1, 0, 5,'h1234));
    tbl.push_back(mk(0,0,0,    0,0,0,      5, 1,1,0, 0, 5,'h1234));
    // Zero-address drop still flips the grant: A wins the next contention.
    tbl.push_back(mk(0,0,0,    1,0,'hFFFF, 0, 1,1,0, 0, 5,'h1234));
    tbl.push_back(mk(1,4,'h44, 1,7,'h77,   0, 1,1,0, 0, 5,'h1234));
    tbl.push_back(mk(0,0,0,    0,0,0,      7, 1,1,1, 1, 4,'h44));
    tbl.push_back(mk(0,0,0,    0,0,0,      7, 1,1,1, 1, 7,'h77));
    tbl.push_back(mk(0,0,0,    0,0,0,      7, 1,1,1, 0, 7,'h77));
    tbl.push_back(mk(0,0,0,    0,0,0,      7, 1,1,0, 0, 7,'h77));

    reset = 0; idle(); a_addr = 0; a_data = 0; b_addr = 0; b_data = 0; q_addr = 5;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_q_pending", q_pending, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1;

    foreach (tbl[i]) begin
      a_valid = tbl[i].av; a_addr = tbl[i].aa; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_addr = tbl[i].ba; b_data = tbl[i].bd;
      q_addr  = tbl[i].qa;
      #1;
      chk($sformatf("vec%0d_a_ready", i), a_ready, tbl[i].ar);
      chk($sformatf("vec%0d_b_ready", i), b_ready, tbl[i].br);
      chk($sformatf("vec%0d_q_pending", i), q_pending, tbl[i].qp);
      run_cycle();
      chk($sformatf("vec%0d_wr_en", i), wr_en, tbl[i].we);
      chk($sformatf("vec%0d_wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("vec%0d_wr_data", i), wr_data, tbl[i].wd);
    end

    // Hazard under backpressure: B keeps its queue full while A queues r9.
    q_addr = 9; idle();
    for (int c = 0; c < 14; c++) begin
      if (!b_valid || acc_b) begin
        b_valid = (c < 8); b_addr = 5'(20 + c); b_data = 32'hB00 + c;
      end
      if (c == 2) begin a_valid = 1; a_addr = 9; a_data = 32'h99; end
      else if (acc_a) a_valid = 0;
      run_cycle();
    end
    q_addr = 0;
    for (int c = 0; c < 3; c++) run_cycle();

    // Backpressure on A: hold each request until accepted, B competing.
    idle();
    for (int c = 0; c < 16; c++) begin
      if (!a_valid || acc_a) begin
        a_valid = (c < 10); a_addr = 5'(1 + c); a_data = 32'hA00 + c;
      end
      if (!b_valid || acc_b) begin
        b_valid = (c < 10); b_addr = 5'(16 + c); b_data = 32'hBB0 + c;
      end
      q_addr = 5'(1 + (c % 8));
      run_cycle();
    end
    idle();
    for (int c = 0; c < 4; c++) run_cycle();

    // Reset mid-stream with both queues holding entries.
    a_valid = 1; a_addr = 3; a_data = 'h33; b_valid = 1; b_addr = 4; b_data = 'h44;
    run_cycle();
    a_addr = 5; a_data = 'h55; b_addr = 6; b_data = 'h66;
    run_cycle();
    idle(); q_addr = 6;
    run_cycle();
    chk("pre_reset_wr_en", wr_en, 1);
    #2 reset = 0;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_wr_addr", wr_addr, 0);
    chk("async_a_ready", a_ready, 0);
    chk("async_b_ready", b_ready, 0);
    chk("async_q_pending", q_pending, 0);
    model_reset();
    @(negedge clk);
    chk("held_rst_wr_en", wr_en, 0);
    reset = 1;
    for (int c = 0; c < 4; c++) run_cycle();

    // Random traffic, requests held until accepted.
    idle();
    for (int c = 0; c < 400; c++) begin
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 99) < 55);
        a_addr = 5'($urandom_range(0, 7)); a_data = $urandom;
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 99) < 55);
        b_addr = 5'($urandom_range(0, 7)); b_data = $urandom;
      end
      q_addr = 5'($urandom_range(0, 7));
      run_cycle();
    end
    idle();
    for (int c = 0; c < 6; c++) run_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of write data (register width).
REQ-002 Parameter ADDR_W, default 5, width of register index (32 registers).
REQ-003 Parameter DEPTH, default 2, entries per requester queue; legal values are powers of two, 2 or larger.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 a_valid  input  1  requester A (ALU writeback) write request.
REQ-007 a_addr  input  ADDR_W  requester A destination register.
REQ-008 a_data  input  DATA_W  requester A write value.
REQ-009 a_ready  output  1  requester A queue can accept a request.
REQ-010 b_valid, b_addr, b_data, b_ready  same as REQ-006 to REQ-009, for requester B (load writeback).
REQ-011 wr_en  output  1  write strobe to the register file write port.
REQ-012 wr_addr  output  ADDR_W  register file destination index.
REQ-013 wr_data  output  DATA_W  register file write value.
REQ-014 q_addr  input  ADDR_W  hazard query register index.
REQ-015 q_pending  output  1  a write to q_addr is queued or in flight.

Function
REQ-016 The block SHALL accept a request on a posedge where x_valid and x_ready are both 1, and SHALL append it to queue x.
REQ-017 x_ready SHALL equal (count_x < DEPTH) from registered state only; a pop in the same cycle SHALL NOT raise x_ready when the queue is full.
REQ-018 On every posedge, the arbiter SHALL pop at most one entry in total, taken from one non-empty queue.
REQ-019 Arbitration SHALL be round-robin: if one queue is non-empty, that queue is granted; if both are non-empty, the queue not granted last is granted; last_grant SHALL update on every pop.
REQ-020 A popped entry with a nonzero address SHALL drive wr_en=1, wr_addr, and wr_data as registered outputs for exactly the one cycle after the pop edge.
REQ-021 A popped entry with address 0 SHALL be discarded: wr_en=0 in the following cycle, but the pop still consumes the grant and updates last_grant.
REQ-022 In every cycle with no pop, wr_en SHALL be 0; wr_addr and wr_data SHALL hold their last values.
REQ-023 Latency from accept edge N to register file write SHALL be a minimum of 1 cycle (wr_en high after edge N+1); a push and an arbiter pop SHALL NOT bypass the queue in the same edge.
REQ-024 Per-requester order SHALL be preserved (FIFO); between requesters, order SHALL follow grant order.
REQ-025 The queue pointers SHALL wrap modulo DEPTH; push and pop on the same queue in the same edge SHALL leave count unchanged.
REQ-026 q_pending SHALL be combinational, and SHALL be 1 when q_addr is nonzero and matches any valid queue entry, or matches wr_addr while wr_en=1.
REQ-027 q_pending SHALL be 0 when q_addr is 0.
REQ-028 An x_valid with x_ready=0 SHALL be ignored; the requester SHALL hold the request stable until it is accepted.

Reset
REQ-029 When reset=0, the block SHALL asynchronously clear both queues (count=0, pointers=0), set wr_en=0, wr_addr=0, wr_data=0, and set last_grant=B so that A wins the first contention.
REQ-030 While reset=0, a_ready and b_ready SHALL be 0, and q_pending SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL drop all queued and in-flight writes; no wr_en pulse SHALL occur after reset is asserted.
REQ-032 After reset deassertion, the first posedge SHALL accept requests normally.

Verification
REQ-033 Single write: a_valid, a_addr=5, a_data=0x1234 for one cycle -> wr_en=1, wr_addr=5, wr_data=0x1234 in exactly one cycle (the cycle after the next edge).
REQ-034 Contention: A and B each push 3 writes back-to-back (A to r1..r3, B to r11..r13) -> write order 1,11,2,12,3,13; ready drops when a queue holds 2 entries.
REQ-035 Zero drop: B pushes addr 0 with data 0xFFFF, then addr 7 -> no wr_en for r0; r7 is written; last_grant still toggles.
REQ-036 Hazard: A pushes r9 while B is full and blocking -> q_addr=9 gives q_pending=1 until the cycle after the r9 write, then 0; q_addr=0 always gives 0.
REQ-037 Backpressure: hold a_valid with A full -> no accept and no loss; the request is accepted on the first edge with a_ready=1.
REQ-038 Reset mid-stream: assert reset with 2+2 entries queued -> wr_en=0 immediately, readies are 0, and after release no stale writes occur.
